// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the run controller and the CPU/debug side: run commands,
// breakpoint setup, the CPU fetch/commit view, and controller status back out.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cmd_run;
  logic             cmd_step;
  logic             cmd_stop;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      cur_pc;
  logic [31:0]      cur_instr;
  logic             commit;
  logic             global_en;
  logic [1:0]       state;
  logic [1:0]       stop_cause;
  logic [31:0]      stop_pc;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output cmd_run, cmd_step, cmd_stop, bp_en, bp_addr, cur_pc, cur_instr, commit,
    input  global_en, state, stop_cause, stop_pc, instr_cnt, cycle_cnt
  );

  modport slave (
    input  cmd_run, cmd_step, cmd_stop, bp_en, bp_addr, cur_pc, cur_instr, commit,
    output global_en, state, stop_cause, stop_pc, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the single-cycle CPU: run / step / stop, one PC
// breakpoint and ebreak halt, plus saturating retired-instruction and cycle counters.
module cpu_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [1:0]  CAUSE_STOP   = 2'b01;
  localparam logic [1:0]  CAUSE_BP     = 2'b10;
  localparam logic [1:0]  CAUSE_EBRK   = 2'b11;

  state_t           state_q, state_n;
  logic [1:0]       cause_q, cause_n;
  logic [31:0]      stop_pc_q, stop_pc_n;
  logic             skip_bp_q, skip_bp_n;
  logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;
  logic             is_ebreak, bp_hit, en;

  assign is_ebreak = (bus.cur_instr == EBREAK_INSTR);
  assign bp_hit    = bus.bp_en & (bus.cur_pc == bus.bp_addr) & ~skip_bp_q;
  assign en        = ((state_q == RUN) & ~bp_hit & ~bus.cmd_stop) | (state_q == STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cause_q   <= 2'b00;
      stop_pc_q <= 32'h0;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cause_q   <= cause_n;
      stop_pc_q <= stop_pc_n;
      skip_bp_q <= skip_bp_n;
    end
  end

  // skip_bp lets a resume from a breakpoint execute that instruction once.
  always_comb begin
    state_n   = state_q;
    cause_n   = cause_q;
    stop_pc_n = stop_pc_q;
    skip_bp_n = skip_bp_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_stop) begin
          state_n = IDLE;
        end else if (bus.cmd_run) begin
          state_n   = RUN;
          skip_bp_n = 1'b1;
        end else if (bus.cmd_step) begin
          state_n = STEP;
        end
      end
      RUN: begin
        if (bus.cmd_stop) begin
          state_n   = IDLE;
          cause_n   = CAUSE_STOP;
          stop_pc_n = bus.cur_pc;
        end else if (bp_hit) begin
          state_n   = IDLE;
          cause_n   = CAUSE_BP;
          stop_pc_n = bus.cur_pc;
        end else begin
          skip_bp_n = 1'b0;
          if (is_ebreak) begin
            state_n   = HALT;
            cause_n   = CAUSE_EBRK;
            stop_pc_n = bus.cur_pc;
          end
        end
      end
      STEP: begin
        stop_pc_n = bus.cur_pc;
        if (is_ebreak) begin
          state_n = HALT;
          cause_n = CAUSE_EBRK;
        end else begin
          state_n = IDLE;
          cause_n = CAUSE_STOP;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Counters saturate at all-ones and hold their value outside RUN/STEP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (en && (cycle_cnt_q != {CNT_W{1'b1}}))
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (bus.commit && (instr_cnt_q != {CNT_W{1'b1}}))
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign bus.global_en  = en;
  assign bus.state      = state_q;
  assign bus.stop_cause = cause_q;
  assign bus.stop_pc    = stop_pc_q;
  assign bus.instr_cnt  = instr_cnt_q;
  assign bus.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny PC+4 CPU model feeds the main instance,
// and a CNT_W=4 instance exercises counter saturation.
module tb_cpu_run_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [31:0] ebreak_addr;
  logic [31:0] cpu_pc;
  logic        cpu_commit;
  logic        sat_commit;

  cpu_run_ctrl_if #(.CNT_W(32)) bus ();
  cpu_run_ctrl_if #(.CNT_W(4))  sbus ();

  cpu_run_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu_run_ctrl #(.CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU model: PC advances when enabled, commit follows execution by one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_pc     <= 32'h0;
      cpu_commit <= 1'b0;
      sat_commit <= 1'b0;
    end else begin
      if (bus.global_en) cpu_pc <= cpu_pc + 32'd4;
      cpu_commit <= bus.global_en;
      sat_commit <= sbus.global_en;
    end
  end

  assign bus.cur_pc    = cpu_pc;
  assign bus.cur_instr = (cpu_pc == ebreak_addr) ? EBREAK : NOP;
  assign bus.commit    = cpu_commit;
  assign sbus.cur_pc    = 32'h100;
  assign sbus.cur_instr = NOP;
  assign sbus.commit    = sat_commit;

  task automatic apply_reset;
    bus.cmd_run  = 1'b0;
    bus.cmd_step = 1'b0;
    bus.cmd_stop = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_run;
    @(negedge clk);
    bus.cmd_run = 1'b1;
    @(negedge clk);
    bus.cmd_run = 1'b0;
  endtask

  task automatic test_reset;
    bus.bp_en = 1'b0;
    bus.bp_addr = 32'h0;
    ebreak_addr = 32'hFFFF_0000;
    apply_reset();
    vectors++;
    if (bus.state !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_state: got %b expected 00", bus.state); end
    vectors++;
    if (bus.global_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en: got %b expected 0", bus.global_en); end
    vectors++;
    if ({bus.stop_cause, bus.stop_pc, bus.instr_cnt, bus.cycle_cnt} !== 98'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: cause %b pc %h ic %0d cc %0d expected all 0",
               bus.stop_cause, bus.stop_pc, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_ebreak_run;
    int en_cnt;
    ebreak_addr = 32'h1C;
    apply_reset();
    pulse_run();
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.state == 2'b11) break;
      if (bus.global_en) en_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (en_cnt !== 8) begin miscompares++; $display("[TB] FAIL ebreak_en_cycles: got %0d expected 8", en_cnt); end
    vectors++;
    if (bus.state !== 2'b11) begin miscompares++; $display("[TB] FAIL ebreak_state: got %b expected 11", bus.state); end
    vectors++;
    if (bus.stop_cause !== 2'b11) begin miscompares++; $display("[TB] FAIL ebreak_cause: got %b expected 11", bus.stop_cause); end
    vectors++;
    if (bus.stop_pc !== 32'h1C) begin miscompares++; $display("[TB] FAIL ebreak_stop_pc: got %h expected 0000001c", bus.stop_pc); end
    vectors++;
    if (bus.cycle_cnt !== 32'd8) begin miscompares++; $display("[TB] FAIL ebreak_cycle_cnt: got %0d expected 8", bus.cycle_cnt); end
    vectors++;
    if (bus.instr_cnt !== 32'd7) begin miscompares++; $display("[TB] FAIL ebreak_instr_lag: got %0d expected 7", bus.instr_cnt); end
    @(negedge clk);
    vectors++;
    if (bus.instr_cnt !== 32'd8) begin miscompares++; $display("[TB] FAIL ebreak_instr_cnt: got %0d expected 8", bus.instr_cnt); end
  endtask

  task automatic test_halt_ignores_cmds;
    @(negedge clk);
    bus.cmd_run = 1'b1;
    @(negedge clk);
    bus.cmd_run  = 1'b0;
    bus.cmd_step = 1'b1;
    @(negedge clk);
    bus.cmd_step = 1'b0;
    vectors++;
    if (bus.state !== 2'b11) begin miscompares++; $display("[TB] FAIL halt_state: got %b expected 11", bus.state); end
    vectors++;
    if (bus.global_en !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_en: got %b expected 0", bus.global_en); end
    vectors++;
    if (bus.cycle_cnt !== 32'd8) begin miscompares++; $display("[TB] FAIL halt_cycle_hold: got %0d expected 8", bus.cycle_cnt); end
  endtask

  task automatic test_breakpoint;
    int en_cnt;
    ebreak_addr = 32'hFFFF_0000;
    apply_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    pulse_run();
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.state != 2'b01) break;
      if (bus.global_en) en_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (en_cnt !== 4) begin miscompares++; $display("[TB] FAIL bp_en_cycles: got %0d expected 4", en_cnt); end
    vectors++;
    if (bus.state !== 2'b00 || bus.stop_cause !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL bp_stop: state %b cause %b expected 00/10", bus.state, bus.stop_cause);
    end
    vectors++;
    if (bus.stop_pc !== 32'h10 || bus.cycle_cnt !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL bp_pc_cnt: pc %h cc %0d expected 00000010/4", bus.stop_pc, bus.cycle_cnt);
    end
    pulse_run();
    vectors++;
    if (bus.global_en !== 1'b1 || cpu_pc !== 32'h10) begin
      miscompares++;
      $display("[TB] FAIL bp_resume: en %b pc %h expected 1/00000010", bus.global_en, cpu_pc);
    end
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.global_en) en_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (en_cnt !== 5 || bus.state !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL bp_no_retrigger: en %0d state %b expected 5/01", en_cnt, bus.state);
    end
    bus.cmd_stop = 1'b1;
    @(negedge clk);
    bus.cmd_stop = 1'b0;
    vectors++;
    if (bus.cycle_cnt !== 32'd9 || bus.stop_cause !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL bp_resume_total: cc %0d cause %b expected 9/01", bus.cycle_cnt, bus.stop_cause);
    end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_single_step;
    int en_cnt;
    ebreak_addr = 32'hFFFF_0000;
    apply_reset();
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.global_en) en_cnt++;
      bus.cmd_step = ((i % 3) == 0) && (i < 9);
    end
    bus.cmd_step = 1'b0;
    vectors++;
    if (en_cnt !== 3) begin miscompares++; $display("[TB] FAIL step_pulses: got %0d expected 3", en_cnt); end
    vectors++;
    if (bus.state !== 2'b00 || bus.stop_cause !== 2'b01 || bus.stop_pc !== 32'h8) begin
      miscompares++;
      $display("[TB] FAIL step_status: state %b cause %b pc %h expected 00/01/00000008",
               bus.state, bus.stop_cause, bus.stop_pc);
    end
    vectors++;
    if (bus.instr_cnt !== 32'd3) begin miscompares++; $display("[TB] FAIL step_instr_cnt: got %0d expected 3", bus.instr_cnt); end
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'hC;
    bus.cmd_step = 1'b1;
    @(negedge clk);
    bus.cmd_step = 1'b0;
    vectors++;
    if (bus.global_en !== 1'b1 || cpu_pc !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL step_over_bp: en %b pc %h expected 1/0000000c", bus.global_en, cpu_pc);
    end
    @(negedge clk);
    vectors++;
    if (bus.stop_pc !== 32'hC || bus.stop_cause !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL step_bp_status: pc %h cause %b expected 0000000c/01", bus.stop_pc, bus.stop_cause);
    end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_stop;
    ebreak_addr = 32'hFFFF_0000;
    apply_reset();
    pulse_run();
    repeat (5) @(negedge clk);
    bus.cmd_stop = 1'b1;
    #1;
    vectors++;
    if (bus.global_en !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_en_drop: got %b expected 0", bus.global_en); end
    @(negedge clk);
    bus.cmd_stop = 1'b0;
    vectors++;
    if (bus.state !== 2'b00 || bus.cycle_cnt !== 32'd5 || bus.stop_pc !== 32'h14) begin
      miscompares++;
      $display("[TB] FAIL stop_status: state %b cc %0d pc %h expected 00/5/00000014",
               bus.state, bus.cycle_cnt, bus.stop_pc);
    end
    bus.cmd_run  = 1'b1;
    bus.cmd_stop = 1'b1;
    @(negedge clk);
    bus.cmd_run  = 1'b0;
    bus.cmd_stop = 1'b0;
    vectors++;
    if (bus.state !== 2'b00 || bus.global_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL run_stop_same: state %b en %b expected 00/0", bus.state, bus.global_en);
    end
  endtask

  task automatic test_async_reset;
    ebreak_addr = 32'hFFFF_0000;
    apply_reset();
    pulse_run();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.global_en !== 1'b0 || bus.state !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL async_rst: en %b state %b expected 0/00", bus.global_en, bus.state);
    end
    vectors++;
    if (bus.cycle_cnt !== 32'd0 || bus.instr_cnt !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL async_rst_cnt: cc %0d ic %0d expected 0/0", bus.cycle_cnt, bus.instr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation;
    @(negedge clk);
    sbus.cmd_run = 1'b1;
    @(negedge clk);
    sbus.cmd_run = 1'b0;
    repeat (14) @(negedge clk);
    vectors++;
    if (sbus.cycle_cnt !== 4'hE) begin miscompares++; $display("[TB] FAIL sat_pre: got %h expected e", sbus.cycle_cnt); end
    repeat (10) @(negedge clk);
    vectors++;
    if (sbus.cycle_cnt !== 4'hF || sbus.instr_cnt !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL sat_hold: cc %h ic %h expected f/f", sbus.cycle_cnt, sbus.instr_cnt);
    end
    vectors++;
    if (sbus.state !== 2'b01 || sbus.global_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_running: state %b en %b expected 01/1", sbus.state, sbus.global_en);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    sbus.cmd_run  = 1'b0;
    sbus.cmd_step = 1'b0;
    sbus.cmd_stop = 1'b0;
    sbus.bp_en    = 1'b0;
    sbus.bp_addr  = 32'h0;
    test_reset();
    test_ebreak_run();
    test_halt_ignores_cmds();
    test_breakpoint();
    test_single_step();
    test_stop();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
